// File: rtl/fir_decim_fifo.sv
// rtl/fir_decim_fifo.sv - FIR output decimator (by 2^DECIM_LOG2) feeding a valid/ready FIFO with sticky overflow
// Optional macro FIR_DECIM_AVG_EN: emit the truncated average of each group instead of its last sample.
module fir_decim_fifo #(
  parameter int DATA_W     = 8,
  parameter int DECIM_LOG2 = 2,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       y_in,
  input  logic                    in_en,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int PH_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PH_W-1:0] LAST_PH  = PH_W'((1 << DECIM_LOG2) - 1);
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

  logic [PH_W-1:0]   phase;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] dec_sample;
  logic              last;
  logic              push;
  logic              pop;
  logic              full;
  logic              wr_en;
  logic              drop;

  // With DECIM_LOG2=0 the phase is pinned at 0, so every accepted sample is the last of its group.
  assign last = (phase == LAST_PH);
  assign push = in_en & last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (in_en) begin
      phase <= last ? '0 : phase + PH_W'(1);
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int ACC_W = DATA_W + DECIM_LOG2;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  // The first sample of a group reloads the sum directly, so no clear cycle is needed.
  assign acc_sum    = (phase == '0) ? ACC_W'(y_in) : acc + ACC_W'(y_in);
  assign dec_sample = DATA_W'(acc_sum >> DECIM_LOG2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (in_en) begin
      acc <= acc_sum;
    end
  end
`else
  assign dec_sample = y_in;
`endif

  assign m_valid = (level != '0);
  assign pop     = m_valid & m_ready;
  assign full    = (level == FULL_LVL);
  // A pop on the same edge frees the slot that a push into a full FIFO needs.
  assign wr_en   = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= dec_sample;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// tb/tb_fir_decim_fifo.sv - scoreboard bench for fir_decim_fifo (D=4 instance plus a pass-through instance)
module tb_fir_decim_fifo;

  localparam int DW    = 8;
  localparam int LOG2  = 2;
  localparam int D     = 4;
  localparam int DEPTH = 8;
`ifdef FIR_DECIM_AVG_EN
  localparam int EXP_BASIC = 25;
`else
  localparam int EXP_BASIC = 40;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] y_in = '0;
  logic          in_en = 1'b0;
  logic          m_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [3:0]    level;
  logic          ovf;

  logic [DW-1:0] pt_y = '0;
  logic          pt_en = 1'b0;
  logic          pt_rdy = 1'b0;
  logic          pt_clr = 1'b0;
  logic [DW-1:0] pt_data;
  logic          pt_valid;
  logic [3:0]    pt_level;
  logic          pt_ovf;

  int checks = 0;
  int errors = 0;
  int q[$];
  int mphase = 0;
  int macc = 0;
  bit exp_ovf = 1'b0;

  always #5 clk = ~clk;

  fir_decim_fifo #(.DATA_W(DW), .DECIM_LOG2(LOG2), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .y_in(y_in), .in_en(in_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  fir_decim_fifo #(.DATA_W(DW), .DECIM_LOG2(0), .DEPTH(DEPTH)) u_pt (
    .clk(clk), .rst(rst), .y_in(pt_y), .in_en(pt_en),
    .m_data(pt_data), .m_valid(pt_valid), .m_ready(pt_rdy),
    .level(pt_level), .ovf(pt_ovf), .ovf_clr(pt_clr)
  );

  // One clock of the D=4 instance: pop-compare against the scoreboard, then model the push.
  task automatic cycle(input bit en, input int y, input bit rdy, input bit clr);
    int e;
    bit drop;
    drop = 1'b0;
    in_en = en;
    y_in = y[7:0];
    m_ready = rdy;
    ovf_clr = clr;
    #1;
    if (rdy && q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (m_valid !== 1'b1 || m_data !== e[7:0]) begin
        errors++;
        $display("FAIL pop_data: got valid=%0b data=%0d, expected valid=1 data=%0d", m_valid, m_data, e);
      end
    end
    if (en) begin
      if (mphase == 0) macc = y; else macc += y;
      if (mphase == D - 1) begin
`ifdef FIR_DECIM_AVG_EN
        e = macc >> LOG2;
`else
        e = y;
`endif
        if (q.size() < DEPTH) q.push_back(e); else drop = 1'b1;
        mphase = 0;
      end else begin
        mphase++;
      end
    end
    if (drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    in_en = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || level !== 4'd0 || ovf !== 1'b0 || m_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b level=%0d ovf=%0b data=%0d, expected all 0", m_valid, level, ovf, m_data);
    end
    checks++;
    if (pt_valid !== 1'b0 || pt_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_state_pt: got valid=%0b level=%0d, expected 0", pt_valid, pt_level);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    cycle(1, 10, 1, 0);
    cycle(1, 20, 1, 0);
    cycle(1, 30, 1, 0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: got valid=%0b, expected 0", m_valid);
    end
    cycle(1, 40, 1, 0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== EXP_BASIC[7:0]) begin
      errors++;
      $display("FAIL basic_out: got valid=%0b data=%0d, expected valid=1 data=%0d", m_valid, m_data, EXP_BASIC);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle: got valid=%0b, expected 0", m_valid);
    end
  endtask

  task automatic test_gaps();
    cycle(1, 10, 1, 0);
    cycle(1, 20, 1, 0);
    repeat (3) cycle(0, 0, 1, 0);
    cycle(1, 30, 1, 0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL gaps_early: got valid=%0b, expected 0", m_valid);
    end
    cycle(1, 40, 1, 0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== EXP_BASIC[7:0]) begin
      errors++;
      $display("FAIL gaps_out: got valid=%0b data=%0d, expected valid=1 data=%0d", m_valid, m_data, EXP_BASIC);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL gaps_after: got valid=%0b, expected 0", m_valid);
    end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 36; k++) begin
      cycle(1, k, 0, 0);
      if (k == 32) begin
        checks++;
        if (level !== 4'd8 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_fill: got level=%0d ovf=%0b, expected level=8 ovf=0", level, ovf);
        end
      end
    end
    checks++;
    if (level !== 4'd8 || ovf !== 1'b1 || exp_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: got level=%0d ovf=%0b, expected level=8 ovf=1", level, ovf);
    end
    repeat (8) cycle(0, 0, 1, 0);
    checks++;
    if (m_valid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL ovf_drain: got valid=%0b level=%0d, expected valid=0 level=0", m_valid, level);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%0b, expected 1", ovf);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (ovf !== exp_ovf || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got ovf=%0b, expected 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    for (int k = 1; k <= 32; k++) cycle(1, 100 + k, 0, 0);
    checks++;
    if (level !== 4'd8) begin
      errors++;
      $display("FAIL full_fill: got level=%0d, expected 8", level);
    end
    cycle(1, 201, 0, 0);
    cycle(1, 202, 0, 0);
    cycle(1, 203, 0, 0);
    cycle(1, 204, 1, 0);
    checks++;
    if (level !== 4'd8 || ovf !== 1'b0 || exp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: got level=%0d ovf=%0b, expected level=8 ovf=0", level, ovf);
    end
    repeat (8) cycle(0, 0, 1, 0);
    checks++;
    if (m_valid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL full_drain: got valid=%0b level=%0d, expected valid=0 level=0", m_valid, level);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 14; k++) cycle(1, k, 0, 0);
    checks++;
    if (level !== 4'd3) begin
      errors++;
      $display("FAIL mid_level: got level=%0d, expected 3", level);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (level !== 4'd0 || m_valid !== 1'b0 || m_data !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got level=%0d valid=%0b data=%0d, expected 0", level, m_valid, m_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    mphase = 0;
    macc = 0;
    exp_ovf = 1'b0;
    cycle(1, 1, 1, 0);
    cycle(1, 2, 1, 0);
    cycle(1, 3, 1, 0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_phase_restart: got valid=%0b, expected 0", m_valid);
    end
    cycle(1, 4, 1, 0);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_group_out: got valid=%0b, expected 1", m_valid);
    end
    cycle(0, 0, 1, 0);
  endtask

  task automatic test_pass_through();
    int vals[3] = '{255, 0, 100};
    int e;
    pt_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pt_en = 1'b1;
      pt_y = vals[i][7:0];
      @(posedge clk);
      #1;
      e = vals[i];
      checks++;
      if (pt_valid !== 1'b1 || pt_data !== e[7:0] || pt_level > 4'd1) begin
        errors++;
        $display("FAIL pass_through[%0d]: got valid=%0b data=%0d level=%0d, expected valid=1 data=%0d level<=1",
                 i, pt_valid, pt_data, pt_level, e);
      end
    end
    pt_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pt_valid !== 1'b0 || pt_level !== 4'd0) begin
      errors++;
      $display("FAIL pass_through_end: got valid=%0b level=%0d, expected 0", pt_valid, pt_level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_pass_through();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
- Downstream stage of the 8-bit FIR filter. Consumes the filter output stream (one sample per enabled clock).
- Decimates the stream by 2^DECIM_LOG2.
- Buffers the decimated samples in a small FIFO.
- Presents the samples to the next consumer over a valid/ready handshake.
- Flags samples lost on overflow with a sticky bit.

Parameters:
- DATA_W, 8, sample width (matches the filter output).
- DECIM_LOG2, 2, log2 of the decimation factor D; D = 4 by default. Legal range 0..4; 0 means pass-through.
- DEPTH, 8, FIFO depth in samples. Must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately.
- y_in  input  DATA_W  filter output sample.
- in_en  input  1  y_in is valid this cycle; a sample is accepted on the edge where in_en=1.
- m_data  output  DATA_W  head-of-FIFO sample.
- m_valid  output  1  FIFO is non-empty.
- m_ready  input  1  consumer accepts the head sample on an edge where m_valid=1 and m_ready=1.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- ovf  output  1  sticky overflow flag.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (rst low, asynchronous):
  - phase=0, accumulator=0, read/write pointers=0.
  - level=0, m_valid=0, m_data=0, ovf=0.
- Phase counter, 0..D-1:
  - Advances only on edges where in_en=1; holds when in_en=0.
  - Wraps from D-1 to 0.
- Decimated sample generation:
  - A decimated sample is produced on the edge where in_en=1 and phase==D-1.
  - Without the optional feature, that sample is the y_in value accepted on that edge, i.e. the last of each group of D.
  - With DECIM_LOG2=0, every accepted sample is produced.
- Push:
  - The produced sample is written into the FIFO on the same edge. There is no extra pipeline stage.
  - m_valid and m_data reflect the sample after that edge (1-cycle latency from the accepting edge).
- Pop:
  - On an edge with m_valid & m_ready, the read pointer advances.
  - m_data is the combinational read of mem[rd_ptr] when level>0, and 0 when empty.
- level update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
- Full (level==DEPTH):
  - Push without pop: sample dropped, ovf set to 1, level and pointers unchanged.
  - Push with pop on the same edge: pop frees the slot and the push is accepted; ovf is not set.
- Empty: m_valid=0, so no pop occurs; a push on the same edge is accepted and level becomes 1.
- ovf_clr:
  - Clears ovf on the next edge.
  - If an overflow drop occurs on that same edge, set wins and ovf stays 1.
- Pointers: DEPTH power of two, so pointers wrap naturally at DEPTH; no special-case logic.
- Reset mid-operation: FIFO contents become don't-care, all outputs return to reset values immediately, and the phase restarts at 0.
- No combinational path from m_ready to m_valid or m_data.

Optional Feature:
Macro FIR_DECIM_AVG_EN.
- Defined:
  - A DATA_W+DECIM_LOG2 bit accumulator sums the D accepted samples of each group (unsigned).
  - The produced sample is (sum of the group) >> DECIM_LOG2, truncating.
  - The accumulator reloads with the first sample of the next group; there is no separate clear cycle.
  - Timing and handshake are unchanged.
- Undefined: no accumulator is instantiated; pick-last decimation as above.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, then release.
   -> m_valid=0, level=0, ovf=0, m_data=0. Drive rst low mid-stream with level=3 -> level=0 and m_valid=0 immediately, before the next edge.
2. Basic decimation, D=4, m_ready=1: y_in=10,20,30,40 on 4 consecutive in_en cycles.
   -> Single output, m_valid high for exactly 1 cycle after the 4th edge.
   -> m_data=40 without the macro; m_data=25 with FIR_DECIM_AVG_EN.
3. Enable gaps: same 4 samples with in_en low for 3 cycles between samples 2 and 3.
   -> Identical output value; output appears 1 cycle after the 4th accepted sample.
4. Overflow: m_ready=0; feed 36 samples of value k (k=1..36).
   -> level reaches 8 after sample 32; sample 36 is dropped and ovf=1.
   -> With m_ready=1, FIFO drains 4,8,...,32 in order (no-avg build), then m_valid=0.
   -> ovf stays 1 until ovf_clr is pulsed.
5. Full with simultaneous push and pop: level=8, m_ready=1 on the push edge.
   -> level stays 8, ovf stays 0, the new sample is appended at the tail, and the head advances by one.
6. Pass-through with DECIM_LOG2=0: y_in=255,0,100 with continuous in_en, m_ready=1.
   -> m_data=255,0,100 on the 3 following cycles; level never exceeds 1.
